// File: rtl/bmr_loader_if.sv
// bmr_loader_if
//   Bus bundle between the bitmap-region loader, the image memory and the
//   match accelerator.
//   mem_rd     : word read strobe (loader -> memory)
//   mem_addr   : word address     (loader -> memory)
//   mem_rdata  : read data, valid one cycle after mem_rd (memory -> loader)
//   acc_start  : one-cycle start pulse (loader -> accelerator)
//   acc_finish : finish level         (accelerator -> loader)
//   master modport is the loader side, slave modport the memory/accelerator side.
interface bmr_loader_if #(
    parameter int unsigned ADDR_W = 14
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              acc_start;
    logic              acc_finish;

    modport master (
        output mem_rd, mem_addr, acc_start,
        input  mem_rdata, acc_finish
    );

    modport slave (
        input  mem_rd, mem_addr, acc_start,
        output mem_rdata, acc_finish
    );
endinterface

// File: rtl/bmr_loader.sv
// bmr_loader
//   Fetches a 64-row x 24-pixel window of the 1-bpp score image, packs it
//   into the 1536-bit bitmap region, starts the match accelerator and reports
//   done once the accelerator finishes.
//   clk, rst        : clock, synchronous active-high reset
//   req             : load-and-match request (only honoured when idle)
//   origin_row/col  : window top row / left pixel column
//   busy            : high whenever not idle
//   done            : one-cycle pulse after the accelerator finishes
//   bmr             : packed window, row 0 at [1535:1512], pixel 0 = MSB
//   bus (master)    : image memory read port and accelerator handshake
module bmr_loader #(
    parameter int unsigned IMG_WORDS = 20,
    parameter int unsigned IMG_ROWS  = 480,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned ROW_W     = 9,
    parameter int unsigned COL_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [ROW_W-1:0] origin_row,
    input  logic [COL_W-1:0] origin_col,
    output logic             busy,
    output logic             done,
    output logic [1535:0]    bmr,
    bmr_loader_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, CAP, GO, WAIT, DONE
    } state_t;

    state_t r_state, w_next;

    logic [ROW_W-1:0] r_org_row;
    logic [COL_W-1:0] r_org_col;
    logic [5:0]       r_row;
    logic [31:0]      r_w0;
    logic [1535:0]    r_bmr;
    logic             r_fin_q;

    logic [ROW_W:0]   w_y;
    logic [COL_W-5:0] w_wi;
    logic [COL_W-5:0] w_wi1;
    logic             w_y_ok;
    logic             w_rd0_ok;
    logic             w_rd1_ok;
    logic [COL_W-5:0] w_word;
    logic [31:0]      w_addr_full;
    logic [4:0]       w_off;
    logic [5:0]       w_sh;
    logic [31:0]      w_w1;
    logic [63:0]      w_shifted;
    logic [23:0]      w_row;
    logic             w_fin_rise;

    // Row/word addressing; one spare bit on each so the bounds checks see
    // the true value instead of a wrapped one.
    assign w_y      = {1'b0, r_org_row} + {{(ROW_W-5){1'b0}}, r_row};
    assign w_wi     = {1'b0, r_org_col[COL_W-1:5]};
    assign w_wi1    = w_wi + 1'b1;
    assign w_y_ok   = 32'(w_y) < IMG_ROWS;
    assign w_rd0_ok = w_y_ok && (32'(w_wi)  < IMG_WORDS);
    assign w_rd1_ok = w_y_ok && (32'(w_wi1) < IMG_WORDS);

    assign w_word      = (r_state == RD1) ? w_wi1 : w_wi;
    assign w_addr_full = 32'(w_y) * IMG_WORDS + 32'(w_word);

    // Funnel shift: row = {w0,w1}[63-off : 40-off]
    assign w_off     = r_org_col[4:0];
    assign w_sh      = 6'd40 - {1'b0, w_off};
    assign w_w1      = w_rd1_ok ? bus.mem_rdata : '0;
    assign w_shifted = {r_w0, w_w1} >> w_sh;
    assign w_row     = w_shifted[23:0];

    // r_fin_q follows acc_finish every cycle, so on the first WAIT cycle it
    // already holds the level seen during GO; a finish left high by the
    // previous job therefore never looks like a new rising edge.
    assign w_fin_rise = bus.acc_finish && !r_fin_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = RD0;
            RD0:     w_next = RD1;
            RD1:     w_next = CAP;
            CAP:     w_next = (r_row == 6'd63) ? GO : RD0;
            GO:      w_next = WAIT;
            WAIT:    if (w_fin_rise) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        bus.acc_start = (r_state == GO);
        bus.mem_rd    = ((r_state == RD0) && w_rd0_ok) ||
                        ((r_state == RD1) && w_rd1_ok);
        bus.mem_addr  = bus.mem_rd ? w_addr_full[ADDR_W-1:0] : '0;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_org_row <= '0;
            r_org_col <= '0;
            r_row     <= '0;
            r_w0      <= '0;
            r_bmr     <= '0;
            r_fin_q   <= 1'b0;
        end else begin
            r_fin_q <= bus.acc_finish;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_org_row <= origin_row;
                        r_org_col <= origin_col;
                        r_row     <= '0;
                        r_bmr     <= '0;
                    end
                end
                RD1: r_w0 <= w_rd0_ok ? bus.mem_rdata : '0;
                CAP: begin
                    r_bmr <= {r_bmr[1511:0], w_row};
                    if (r_row != 6'd63) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bmr = r_bmr;

endmodule
